fetch_aligner: RTL and testbench

Instruction-fetch aligner for the RV32IC pipeline, sitting between the word-wide instruction memory and the decode stage. It issues word-aligned fetch requests and buffers the returned words. It reassembles 16-bit and 32-bit instructions at any halfword boundary and hands decode one instruction per cycle with its PC and `compressed_flag`. It also absorbs redirects from the branch/jump path.

---
 rtl/fetch_aligner.sv | 213 +++++++++++++++++++++
 tb/tb_fetch_aligner.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_aligner.sv
// rtl/fetch_aligner.sv - RV32IC fetch aligner; FETCH_ALIGN_C_EN enables compressed (16-bit) instruction support
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        compressed_flag,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  // Without compressed support every PC is word aligned, so bit 1 is dropped too.
`ifdef FETCH_ALIGN_C_EN
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
`else
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [31:0] fetch_addr;
  logic        pending;
  logic [31:0] q_head;
  logic [31:0] q_tail;
  logic [1:0]  q_count;
  logic        head_valid;
  logic        push;
  logic        pop;
  logic        load_en;
  logic        emit;
  logic [31:0] emit_instr;
  logic        emit_comp;
  logic [31:0] next_pc;
  logic [2:0]  q_demand;

  // Only a response to a request we still own is accepted; redirect and reset clear pending.
  assign push       = pending && mem_rvalid;
  assign head_valid = (q_count != 2'd0);
  assign load_en    = !instr_valid || instr_ready;

  // Words already held plus words on the way, minus the one leaving this cycle.
  assign q_demand = {1'b0, q_count} + {2'b00, pending} - {2'b00, pop};
  assign mem_req  = rst && !redirect && (q_demand < 3'd2);
  assign mem_addr = fetch_addr;

  // Fetch address and outstanding-request tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_addr <= RESET_PC & WORD_MASK;
      pending    <= 1'b0;
    end else if (redirect) begin
      fetch_addr <= redirect_pc & WORD_MASK;
      pending    <= 1'b0;
    end else begin
      pending <= mem_req;
      if (mem_req) begin
        fetch_addr <= fetch_addr + 32'd4;
      end
    end
  end

  // Two-entry word queue; q_head is always the oldest word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_count <= 2'd0;
      q_head  <= 32'h0;
      q_tail  <= 32'h0;
    end else if (redirect) begin
      q_count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (q_count == 2'd0) begin
            q_head <= mem_rdata;
          end else begin
            q_tail <= mem_rdata;
          end
          q_count <= q_count + 2'd1;
        end
        2'b01: begin
          q_head  <= q_tail;
          q_count <= q_count - 2'd1;
        end
        2'b11: begin
          if (q_count == 2'd1) begin
            q_head <= mem_rdata;
          end else begin
            q_head <= q_tail;
            q_tail <= mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FETCH_ALIGN_C_EN
  localparam logic [1:0] ST_ALIGNED = 2'd0;
  localparam logic [1:0] ST_HALF    = 2'd1;
  localparam logic [1:0] ST_SKIP    = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] leftover;
  logic [15:0] leftover_nxt;

  // Halfword reassembly: decide what to emit and whether the head word is consumed.
  always_comb begin
    emit         = 1'b0;
    emit_instr   = 32'h0;
    emit_comp    = 1'b0;
    pop          = 1'b0;
    state_nxt    = state;
    leftover_nxt = leftover;
    case (state)
      ST_ALIGNED: begin
        if (head_valid && load_en) begin
          emit = 1'b1;
          pop  = 1'b1;
          if (q_head[1:0] != 2'b11) begin
            emit_instr   = {16'h0, q_head[15:0]};
            emit_comp    = 1'b1;
            leftover_nxt = q_head[31:16];
            state_nxt    = ST_HALF;
          end else begin
            emit_instr = q_head;
          end
        end
      end
      ST_HALF: begin
        if (load_en) begin
          if (leftover[1:0] != 2'b11) begin
            emit       = 1'b1;
            emit_instr = {16'h0, leftover};
            emit_comp  = 1'b1;
            state_nxt  = ST_ALIGNED;
          end else if (head_valid) begin
            // 32-bit instruction straddling two words.
            emit         = 1'b1;
            pop          = 1'b1;
            emit_instr   = {q_head[15:0], leftover};
            leftover_nxt = q_head[31:16];
          end
        end
      end
      ST_SKIP: begin
        // Target sits in the upper half: drop the lower half, nothing is emitted.
        if (head_valid) begin
          pop          = 1'b1;
          leftover_nxt = q_head[31:16];
          state_nxt    = ST_HALF;
        end
      end
      default: begin
        state_nxt = ST_ALIGNED;
      end
    endcase
  end

  // Aligner state and leftover halfword.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RESET_PC[1] ? ST_SKIP : ST_ALIGNED;
      leftover <= 16'h0;
    end else if (redirect) begin
      state    <= redirect_pc[1] ? ST_SKIP : ST_ALIGNED;
      leftover <= 16'h0;
    end else begin
      state    <= state_nxt;
      leftover <= leftover_nxt;
    end
  end
`else
  // Word-only build: every head word is one 32-bit instruction.
  always_comb begin
    pop        = head_valid && load_en;
    emit       = pop;
    emit_instr = q_head;
    emit_comp  = 1'b0;
  end
`endif

  // Output register; holds while decode stalls, next_pc tracks the following instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_valid     <= 1'b0;
      instr_o         <= 32'h0;
      compressed_flag <= 1'b0;
      instr_pc        <= RESET_PC & PC_MASK;
      next_pc         <= RESET_PC & PC_MASK;
    end else if (redirect) begin
      instr_valid <= 1'b0;
      next_pc     <= redirect_pc & PC_MASK;
    end else if (load_en) begin
      instr_valid <= emit;
      if (emit) begin
        instr_o         <= emit_instr;
        compressed_flag <= emit_comp;
        instr_pc        <= next_pc;
        next_pc         <= next_pc + (emit_comp ? 32'd2 : 32'd4);
      end
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// tb/tb_fetch_aligner.sv - scoreboard testbench for fetch_aligner
`timescale 1ns/1ps
module tb_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [31:0] instr_o;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        compressed_flag;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        comp;
  } exp_t;

  exp_t        sb[$];
  exp_t        got_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [logic [31:0]];
  logic        req_s;
  logic [31:0] addr_s;

  fetch_aligner dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .mem_rvalid      (mem_rvalid),
    .instr_o         (instr_o),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .compressed_flag (compressed_flag),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [31:0] pc, input logic [31:0] ins, input logic comp);
    exp_t e;
    e.pc    = pc;
    e.instr = ins;
    e.comp  = comp;
    sb.push_back(e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    step();
    redirect    = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d outstanding expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Memory: sample the request away from the edge, answer one cycle later.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      req_s  = mem_req;
      addr_s = mem_addr;
      @(posedge clk);
      #1;
      mem_rvalid = req_s;
      mem_rdata  = req_s ? mem_read(addr_s) : 32'h0;
    end
  end

  // Scoreboard monitor: every accepted instruction is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst && instr_valid && instr_ready && sb.size() > 0) begin
      got_e = sb.pop_front();
      check("out_pc", instr_pc, got_e.pc);
      check("out_instr", instr_o, got_e.instr);
      check("out_flag", 32'(compressed_flag), 32'(got_e.comp));
    end
  end

  initial begin
    rst         = 1'b0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    mem[32'h000] = 32'h0000_0013;
    mem[32'h004] = 32'h0010_0093;
    mem[32'h100] = 32'h4485_AAAA;
    mem[32'h200] = 32'h0513_4505;
    mem[32'h204] = 32'h0001_00A0;
    mem[32'h300] = 32'h4505_4485;
    for (int i = 0; i < 8; i++) mem[32'h400 + 32'(4 * i)] = 32'h0000_0013 | (32'(i) << 7);
    mem[32'h500] = 32'h0000_4505;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_flag", 32'(compressed_flag), 32'h0);
    check("rst_pc", instr_pc, 32'h0);

    // Aligned start after reset, with first-output latency.
    @(posedge clk);
    #1;
    rst = 1'b1;
    expect_out(32'h0, 32'h0000_0013, 1'b0);
    expect_out(32'h4, 32'h0010_0093, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("c0_mem_req", 32'(mem_req), 32'h1);
        check("c0_mem_addr", mem_addr, 32'h0);
      end
      check($sformatf("reset_lat_valid_c%0d", c), 32'(instr_valid), 32'(c == 3));
      step();
    end
    drain("reset");

    // Mixed straddle, redirect taken while decode is accepting.
    do_redirect(32'h200);
`ifdef FETCH_ALIGN_C_EN
    expect_out(32'h200, 32'h0000_4505, 1'b1);
    expect_out(32'h202, 32'h00A0_0513, 1'b0);
    expect_out(32'h206, 32'h0000_0001, 1'b1);
    expect_out(32'h208, 32'h0000_0013, 1'b0);
`else
    expect_out(32'h200, 32'h0513_4505, 1'b0);
    expect_out(32'h204, 32'h0001_00A0, 1'b0);
    expect_out(32'h208, 32'h0000_0013, 1'b0);
`endif
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("redir_mem_req", 32'(mem_req), 32'h1);
        check("redir_mem_addr", mem_addr, 32'h200);
      end
      check($sformatf("redir_lat_valid_r%0d", c), 32'(instr_valid), 32'(c == 4));
      step();
    end
    drain("straddle");

    // Back-to-back redirects, the second one wins; two compressed in one word.
    redirect    = 1'b1;
    redirect_pc = 32'h600;
    step();
    redirect_pc = 32'h300;
    step();
    redirect    = 1'b0;
`ifdef FETCH_ALIGN_C_EN
    expect_out(32'h300, 32'h0000_4485, 1'b1);
    expect_out(32'h302, 32'h0000_4505, 1'b1);
    expect_out(32'h304, 32'h0000_0013, 1'b0);
`else
    expect_out(32'h300, 32'h4505_4485, 1'b0);
    expect_out(32'h304, 32'h0000_0013, 1'b0);
`endif
    @(negedge clk);
    check("b2b_mem_addr", mem_addr, 32'h300);
    step();
    drain("two_comp");

    // Backpressure: output frozen, fetch stops once the queue is full.
    instr_ready = 1'b0;
    do_redirect(32'h400);
    for (int i = 0; i < 8; i++) expect_out(32'h400 + 32'(4 * i), 32'h0000_0013 | (32'(i) << 7), 1'b0);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!instr_valid && n < 10) begin
        step();
        @(negedge clk);
        n++;
      end
    end
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_valid_%0d", c), 32'(instr_valid), 32'h1);
      check($sformatf("bp_instr_%0d", c), instr_o, 32'h0000_0013);
      check($sformatf("bp_pc_%0d", c), instr_pc, 32'h400);
      check($sformatf("bp_mem_req_%0d", c), 32'(mem_req), 32'h0);
      step();
      @(negedge clk);
    end
    step();
    instr_ready = 1'b1;
    drain("backpressure");

    // Misaligned redirect right after a request: the in-flight response is stale.
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!mem_req && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("pre_redir_mem_req", 32'(mem_req), 32'h1);
    end
    step();
    do_redirect(32'h102);
`ifdef FETCH_ALIGN_C_EN
    expect_out(32'h102, 32'h0000_4485, 1'b1);
`else
    expect_out(32'h100, 32'h4485_AAAA, 1'b0);
`endif
    expect_out(32'h104, 32'h0000_0013, 1'b0);
    @(negedge clk);
    check("mis_mem_req", 32'(mem_req), 32'h1);
    check("mis_mem_addr", mem_addr, 32'h100);
    step();
    drain("misaligned");

    // A compressed-looking word.
    do_redirect(32'h500);
`ifdef FETCH_ALIGN_C_EN
    expect_out(32'h500, 32'h0000_4505, 1'b1);
    expect_out(32'h502, 32'h0000_0000, 1'b1);
`else
    expect_out(32'h500, 32'h0000_4505, 1'b0);
`endif
    expect_out(32'h504, 32'h0000_0013, 1'b0);
    drain("c_word");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
